// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and constants for the UART clock divider controller
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_LOAD    = 2'd2,
    ST_RESTART = 2'd3
  } state_t;

  localparam logic [1:0] PRESC_32  = 2'b00;
  localparam logic [1:0] PRESC_16  = 2'b01;
  localparam logic [1:0] PRESC_8   = 2'b10;
  localparam logic [1:0] PRESC_BAD = 2'b11;

  // Reset ratios, also used where the system_clk_div instances are parameterised
  localparam int RST_TX_DIV_C = 128;
  localparam int RST_RX_DIV_C = 4;

  function automatic logic [2:0] presc_shift(input logic [1:0] code);
    logic [2:0] sh;
    case (code)
      PRESC_32: sh = 3'd5;
      PRESC_16: sh = 3'd4;
      PRESC_8:  sh = 3'd3;
      default:  sh = 3'd0;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/cyc_timer.sv
// rtl/cyc_timer.sv - loadable 4-bit down-counter with a zero flag
module cyc_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - validates divider requests and applies them via stop/load/restart
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int RATIO_W       = 8,
  parameter int DRAIN_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int RST_TX_DIV    = RST_TX_DIV_C,
  parameter int RST_RX_DIV    = RST_RX_DIV_C
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [RATIO_W-1:0] cfg_tx_div,
  input  logic [1:0]         cfg_prescale,
  output logic [RATIO_W-1:0] tx_ratio,
  output logic [RATIO_W-1:0] rx_ratio,
  output logic               div_en,
  output logic               busy,
  output logic               cfg_done,
  output logic               cfg_err
);

  localparam logic [3:0] DRAIN_LD  = 4'(DRAIN_CYCLES - 1);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES - 1);

  state_t             state, next_state;
  logic               accept, legal, tmr_zero, tmr_load, tmr_dec;
  logic [2:0]         shift;
  logic [RATIO_W-1:0] rx_calc, shadow_tx, shadow_rx;
  logic               div_en_d, busy_d, ready_d, done_d, err_d;
  logic [3:0]         tmr_val;

  assign accept  = cfg_valid && cfg_ready;
  assign shift   = presc_shift(cfg_prescale);
  assign rx_calc = cfg_tx_div >> shift;
  // Any bit lost by the shift means the divisor is not a whole multiple of the prescale
  assign legal   = (cfg_prescale != PRESC_BAD) && (cfg_tx_div != '0)
                   && ((rx_calc << shift) == cfg_tx_div);

  assign tmr_load = (accept && legal) || (state == ST_LOAD);
  assign tmr_val  = (state == ST_LOAD) ? SETTLE_LD : DRAIN_LD;
  assign tmr_dec  = (state == ST_DRAIN) || (state == ST_RESTART);

  cyc_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (accept && legal) next_state = ST_DRAIN;
      ST_DRAIN:   if (tmr_zero)        next_state = ST_LOAD;
      ST_LOAD:                         next_state = ST_RESTART;
      ST_RESTART: if (tmr_zero)        next_state = ST_IDLE;
      default:                         next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next_state and registered so they never glitch
  always_comb begin
    div_en_d = !((next_state == ST_DRAIN) || (next_state == ST_LOAD));
    busy_d   = (next_state != ST_IDLE);
    ready_d  = (next_state == ST_IDLE);
    done_d   = (state == ST_RESTART) && (next_state == ST_IDLE);
    err_d    = accept && !legal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_en    <= 1'b1;
      busy      <= 1'b0;
      cfg_ready <= 1'b1;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      div_en    <= div_en_d;
      busy      <= busy_d;
      cfg_ready <= ready_d;
      cfg_done  <= done_d;
      cfg_err   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_tx <= RATIO_W'(RST_TX_DIV);
      shadow_rx <= RATIO_W'(RST_RX_DIV);
      tx_ratio  <= RATIO_W'(RST_TX_DIV);
      rx_ratio  <= RATIO_W'(RST_RX_DIV);
    end else begin
      if (accept && legal) begin
        shadow_tx <= cfg_tx_div;
        shadow_rx <= rx_calc;
      end
      if (state == ST_DRAIN && tmr_zero) begin
        tx_ratio <= shadow_tx;
        rx_ratio <= shadow_rx;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - randomized self-checking bench for clk_div_ctrl
module tb_clk_div_ctrl;

  localparam int W = 8;
  localparam int D = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_tx_div = '0;
  logic [1:0]   cfg_prescale = 2'b00;
  logic         cfg_ready, div_en, busy, cfg_done, cfg_err;
  logic [W-1:0] tx_ratio, rx_ratio;

  clk_div_ctrl #(
    .RATIO_W       (W),
    .DRAIN_CYCLES  (D),
    .SETTLE_CYCLES (S),
    .RST_TX_DIV    (128),
    .RST_RX_DIV    (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_tx_div   (cfg_tx_div),
    .cfg_prescale (cfg_prescale),
    .tx_ratio     (tx_ratio),
    .rx_ratio     (rx_ratio),
    .div_en       (div_en),
    .busy         (busy),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Reference model: the most recent legal accept cycle plus old/new ratio pairs
  bit act    = 1'b0;
  int t_acc  = 0;
  int err_t  = -10;
  int old_tx = 128, old_rx = 4, new_tx = 128, new_rx = 4;

  function automatic bit in_win(int c, int lo, int hi);
    return act && (c >= t_acc + lo) && (c <= t_acc + hi);
  endfunction

  function automatic bit exp_busy(int c);
    return in_win(c, 1, D + S + 1);
  endfunction

  function automatic int exp_tx(int c);
    return (act && c >= t_acc + D + 1) ? new_tx : old_tx;
  endfunction

  function automatic int exp_rx(int c);
    return (act && c >= t_acc + D + 1) ? new_rx : old_rx;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit v, input int d, input int p, input bit r);
    int  pval;
    bit  legal;
    @(negedge clk);
    if (chk_en) begin
      check("cfg_ready", int'(cfg_ready), int'(!exp_busy(cyc)));
      check("busy",      int'(busy),      int'(exp_busy(cyc)));
      check("div_en",    int'(div_en),    int'(!in_win(cyc, 1, D + 1)));
      check("tx_ratio",  int'(tx_ratio),  exp_tx(cyc));
      check("rx_ratio",  int'(rx_ratio),  exp_rx(cyc));
      check("cfg_done",  int'(cfg_done),  int'(act && cyc == t_acc + D + S + 2));
      check("cfg_err",   int'(cfg_err),   int'(cyc == err_t + 1));
    end
    if (r) begin
      act = 1'b0; old_tx = 128; old_rx = 4; err_t = -10;
    end else if (v && !exp_busy(cyc)) begin
      pval  = 32 >> p;
      legal = (p != 3) && (d != 0) && (d % pval == 0);
      if (legal) begin
        old_tx = exp_tx(cyc);
        old_rx = exp_rx(cyc);
        new_tx = d;
        new_rx = d / pval;
        t_acc  = cyc;
        act    = 1'b1;
      end else begin
        err_t = cyc;
      end
    end
    rst          = r;
    cfg_valid    = v;
    cfg_tx_div   = d[W-1:0];
    cfg_prescale = p[1:0];
    @(posedge clk);
    cyc++;
    chk_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    int p, d, sh;
    step(1'b0, 0, 0, 1'b1);
    step(1'b0, 0, 0, 1'b1);
    idle(2);

    step(1'b1, 96, 1, 1'b0);
    idle(10);

    step(1'b1, 100, 0, 1'b0);
    idle(2);
    step(1'b1, 64, 3, 1'b0);
    idle(2);
    step(1'b1, 0, 1, 1'b0);
    idle(3);

    // Requests during DRAIN are ignored; the held one is taken in the done cycle
    step(1'b1, 48, 2, 1'b0);
    step(1'b1, 16, 1, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    step(1'b1, 64, 0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 40, 2, 1'b0);
    idle(10);

    step(1'b1, 200, 2, 1'b0);
    idle(5);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b1);
    idle(4);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        step(1'b0, 0, 0, 1'b1);
      end else begin
        p  = int'($urandom_range(0, 3));
        sh = (p == 3) ? 0 : 5 - p;
        d  = int'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) d = (d >> sh) << sh;
        step($urandom_range(0, 2) == 0, d, p, 1'b0);
      end
    end
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Runtime reconfiguration controller for the UART clock dividers. Accepts a baud divisor plus an oversampling prescale from the register file over a valid/ready handshake, validates them, and computes the TX and RX divide ratios. Updates the ratios with a fixed stop → load → restart sequence so neither divided clock glitches. Sits between the register file and the two `system_clk_div` instances: TX clock and RX oversample clock.

## Interface
- `RATIO_W`, 8: width of divisor and ratio buses.
- `DRAIN_CYCLES`, 4: cycles `div_en` is held low before ratios change; range 1..15.
- `SETTLE_CYCLES`, 2: cycles after `div_en` reasserts before `cfg_done`; range 1..15.
- `RST_TX_DIV`, 128: TX ratio after reset.
- `RST_RX_DIV`, 4: RX ratio after reset (128 / 32).
- `clk`  in  1  system reference clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `cfg_valid`  in  1  configuration request.
- `cfg_ready`  out  1  high only in IDLE.
- `cfg_tx_div`  in  RATIO_W  TX divisor (ref clocks per bit).
- `cfg_prescale`  in  2  prescale code: 00 = 32, 01 = 16, 10 = 8, 11 = illegal.
- `tx_ratio`  out  RATIO_W  to the TX divider ratio input.
- `rx_ratio`  out  RATIO_W  to the RX divider ratio input.
- `div_en`  out  1  enable to both dividers; low holds them stopped.
- `busy`  out  1  high in any state other than IDLE.
- `cfg_done`  out  1  one-cycle pulse when a new configuration is running.
- `cfg_err`  out  1  one-cycle pulse when a request is rejected.

## Operation
- States:
  - IDLE: `cfg_ready` = 1. On accept with legal config → DRAIN.
  - DRAIN: `div_en` = 0, counts DRAIN_CYCLES → LOAD.
  - LOAD: 1 cycle, `div_en` = 0 → RESTART.
  - RESTART: `div_en` = 1, counts SETTLE_CYCLES → IDLE, with a `cfg_done` pulse.
- Accept happens when `cfg_valid & cfg_ready`. Inputs are latched into shadow registers in the accept cycle.
- Legality check at accept:
  - `cfg_prescale` != 11.
  - `cfg_tx_div` != 0.
  - `cfg_tx_div` is an exact multiple of the prescale, i.e. the low log2(prescale) bits are zero.
- `rx_ratio = cfg_tx_div >> log2(prescale)`. This is an unsigned logical shift, never rounded.
- Illegal request: `cfg_err` pulses, state stays IDLE, and the outputs and shadow registers are unchanged.
- A request equal to the current configuration still runs the full sequence.
- `cfg_valid` while busy is ignored and not queued. The requester must hold `cfg_valid` until it sees `cfg_ready`.
- `tx_ratio` and `rx_ratio` change only on entry to LOAD, which is always while `div_en` = 0.

## Timing
- Reset values, effective from the first edge with `rst` high:
  - State IDLE; counter 0.
  - `tx_ratio` = RST_TX_DIV, `rx_ratio` = RST_RX_DIV.
  - `div_en` = 1, `cfg_ready` = 1.
  - `busy` = 0, `cfg_done` = 0, `cfg_err` = 0.
- Legal accept at edge T gives, all outputs registered:
  - `cfg_ready` and `busy` change at T+1.
  - `div_en` = 0 from T+1 to T+DRAIN_CYCLES+1.
  - Ratios take the new values at T+DRAIN_CYCLES+1 (LOAD).
  - `div_en` = 1 at T+DRAIN_CYCLES+2.
  - `cfg_done` = 1 and `cfg_ready` = 1 at T+DRAIN_CYCLES+SETTLE_CYCLES+2.
- A new request can be accepted in the same cycle `cfg_done` is high.
- Illegal accept at T: `cfg_err` = 1 at T+1, and `cfg_ready` stays 1 throughout.
- `rst` asserted mid-sequence, in any state: at the next edge all outputs take their reset values. This includes `div_en` = 1 with the reset ratios. No `cfg_done` is issued.
- Counter width is 4 bits and counts down. DRAIN/SETTLE of 0 is unsupported.

## Structure
- Shared package `clk_div_pkg`:
  - State enum (IDLE, DRAIN, LOAD, RESTART).
  - Prescale code constants and the code → shift-amount function.
  - Reset ratio constants, shared with the `system_clk_div` instantiation.
- One natural sub-module, `cyc_timer`: a loadable 4-bit down-counter with a `zero` flag. It is reused for DRAIN and RESTART.
- Legality check and shift stay inline in `clk_div_ctrl`.

## Test plan
- Reset: hold `rst` for 3 cycles during RESTART → next edge shows `tx_ratio`=128, `rx_ratio`=4, `div_en`=1, `busy`=0, and no `cfg_done`.
- Legal update, accept at T with `cfg_tx_div`=96 and prescale 01 (16):
  - `div_en` low T+1..T+5.
  - Ratios become 96/6 at T+5.
  - `div_en` high at T+6.
  - `cfg_done` at T+8.
- Illegal requests:
  - `cfg_tx_div`=100 with prescale 00 (not divisible by 32) → `cfg_err` at T+1, ratios stay 128/4, `div_en` never drops.
  - Code 11 → same response.
  - `cfg_tx_div`=0 → same response.
- Busy and back-to-back:
  - Toggle `cfg_valid` with different values during DRAIN → ignored; final ratios match the first request.
  - A second request presented in the `cfg_done` cycle → accepted immediately.
- Integration: connect two `system_clk_div` instances and switch 128/32 → 24/8 → `tx_ratio` 24, `rx_ratio` 3. Checker confirms:
  - No divided-clock pulse shorter than one reference period.
  - New periods of 24 and 3 reference cycles after RESTART.
